// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store front-end: opcodes, FSM states,
// access sizes and opcode decode helpers.
// No ports (package).
package mem_access_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op >= OP_SB);
  endfunction

  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Purpose: insert a byte or halfword into a 32-bit word (little-endian lanes).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: i_word (original word), i_data (new lane data in low bits),
//        i_off (byte offset), i_size (lane width), o_word (merged word).
module mau_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [15:0] i_data,
  input  logic [1:0]  i_off,
  input  size_t       i_size,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = i_word;
    case (i_size)
      SZ_B: begin
        case (i_off)
          2'd0:    o_word[7:0]   = i_data[7:0];
          2'd1:    o_word[15:8]  = i_data[7:0];
          2'd2:    o_word[23:16] = i_data[7:0];
          default: o_word[31:24] = i_data[7:0];
        endcase
      end
      SZ_H: begin
        // Halfwords are 2-byte aligned, so only off[1] selects the lane.
        if (i_off[1]) o_word[31:16] = i_data;
        else          o_word[15:0]  = i_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: byte-addressed load/store front-end onto word-indexed data_mem.
// Latency: accept->resp_valid 2 cycles (loads, SW), 3 (SB/SH), 1 (errors).
// Backpressure: one request outstanding; req_ready low until response taken.
// Ports: i_clk/i_reset; request i_req_valid/o_req_ready/i_req_op/i_req_addr/
//        i_req_wdata; response o_resp_valid/i_resp_ready/o_resp_rdata/
//        o_resp_err; memory o_mem_read/o_mem_write/o_mem_addr/o_mem_wdata/
//        i_mem_rdata.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int WADDR_W   = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [32:0] BYTE_LIMIT = 33'(4 * MEM_WORDS);

  state_t             r_state, w_next;
  logic [2:0]         r_op;
  logic [WADDR_W+1:0] r_addr;
  logic [31:0]        r_wdata, r_merge, r_rdata;
  logic               r_err;

  size_t       w_req_size;
  logic        w_bad;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val, w_merged;

  // Request checks look at the live request; they only matter in IDLE.
  always_comb begin
    w_req_size = op_size(i_req_op);
    w_bad      = ({1'b0, i_req_addr} >= BYTE_LIMIT)
               || ((w_req_size == SZ_H) && i_req_addr[0])
               || ((w_req_size == SZ_W) && (i_req_addr[1:0] != 2'b00));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (w_bad)                   w_next = ST_RESP;
          else if (is_load(i_req_op))  w_next = ST_LOAD;
          else if (is_store(i_req_op) && (w_req_size == SZ_W))
                                       w_next = ST_STORE;
          else                         w_next = ST_RMW_RD;
        end
      end
      ST_LOAD, ST_STORE, ST_RMW_WR: w_next = ST_RESP;
      ST_RMW_RD:                    w_next = ST_RMW_WR;
      ST_RESP: if (i_resp_ready)    w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  // Load lane extraction from the live memory read data.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_op)
      OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
      OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
      OP_LBU:  w_load_val = {24'd0, w_byte};
      OP_LHU:  w_load_val = {16'd0, w_half};
      default: w_load_val = i_mem_rdata;
    endcase
  end

  mau_lane_merge u_merge (
    .i_word (r_merge),
    .i_data (r_wdata[15:0]),
    .i_off  (r_addr[1:0]),
    .i_size (op_size(r_op)),
    .o_word (w_merged)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LB;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_op    <= i_req_op;
            r_addr  <= i_req_addr[WADDR_W+1:0];
            r_wdata <= i_req_wdata;
            r_err   <= w_bad;
            r_rdata <= '0;
          end
        end
        ST_LOAD:   r_rdata <= w_load_val;
        ST_RMW_RD: r_merge <= i_mem_rdata;
        default: ;
      endcase
    end
  end

  // Memory strobes come from the state register alone, so reset kills a
  // pending write asynchronously and req_* never reaches mem_* in one cycle.
  always_comb begin
    o_req_ready  = (r_state == ST_IDLE);
    o_resp_valid = (r_state == ST_RESP);
    o_resp_rdata = r_rdata;
    o_resp_err   = r_err;
    o_mem_read   = (r_state == ST_LOAD) || (r_state == ST_RMW_RD);
    o_mem_write  = (r_state == ST_STORE) || (r_state == ST_RMW_WR);
    o_mem_addr   = {{(32 - WADDR_W){1'b0}}, r_addr[WADDR_W+1:2]};
    o_mem_wdata  = '0;
    if (r_state == ST_STORE)  o_mem_wdata = r_wdata;
    if (r_state == ST_RMW_WR) o_mem_wdata = w_merged;
  end

endmodule
